// File: rtl/dallanma_pkg.sv
// Shared types for the execute-stage branch resolver: FSM states, prediction record, PC step.
// Optional counters are enabled by the DALLANMA_SAYAC_EN macro in dallanma_cozumleyici.
package dallanma_pkg;

  localparam int unsigned PS_W     = 32;
  localparam logic [PS_W-1:0] PS_ADIM = 32'd4;

  typedef enum logic {
    CALIS   = 1'b0,
    TEMIZLE = 1'b1
  } durum_e;

  // 65-bit fetch-time prediction record
  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic            atladi;
    logic [PS_W-1:0] hedef;
  } tahmin_t;

  localparam int unsigned TAHMIN_W = $bits(tahmin_t);

  function automatic logic [PS_W-1:0] sonraki_ps(input logic [PS_W-1:0] ps);
    return ps + PS_ADIM;
  endfunction

endpackage

// File: rtl/tahmin_kuyrugu.sv
// In-order prediction FIFO with push, pop and single-cycle clear (clear wins over push/pop).
module tahmin_kuyrugu
  import dallanma_pkg::*;
#(
  parameter int unsigned DERINLIK = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    itme,
  input  logic    cekme,
  input  logic    temizle,
  input  tahmin_t yazilan,
  output tahmin_t bas,
  output logic    bos,
  output logic    dolu
);

  localparam int unsigned PTR_W   = $clog2(DERINLIK);
  localparam int unsigned SAYAC_W = PTR_W + 1;

  tahmin_t            bellek [DERINLIK];
  logic [PTR_W-1:0]   yaz_ptr;
  logic [PTR_W-1:0]   oku_ptr;
  logic [SAYAC_W-1:0] sayac;
  logic               itme_ok;
  logic               cekme_ok;

  assign bos      = (sayac == '0);
  assign dolu     = (sayac == SAYAC_W'(DERINLIK));
  assign itme_ok  = itme && !dolu;
  assign cekme_ok = cekme && !bos;
  assign bas      = bellek[oku_ptr];

  always_ff @(posedge clk_i) begin
    if (itme_ok) begin
      bellek[yaz_ptr] <= yazilan;
    end
  end

  // Pointers wrap naturally because DERINLIK is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i || temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else begin
      if (itme_ok) begin
        yaz_ptr <= yaz_ptr + PTR_W'(1);
      end
      if (cekme_ok) begin
        oku_ptr <= oku_ptr + PTR_W'(1);
      end
      case ({itme_ok, cekme_ok})
        2'b10:   sayac <= sayac + SAYAC_W'(1);
        2'b01:   sayac <= sayac - SAYAC_W'(1);
        default: sayac <= sayac;
      endcase
    end
  end

endmodule

// File: rtl/dallanma_cozumleyici.sv
// Execute-stage branch resolver: checks queued predictions, trains the predictor, flushes on mispredict.
// Define DALLANMA_SAYAC_EN to build the saturating resolution/mispredict counters.
module dallanma_cozumleyici
  import dallanma_pkg::*;
#(
  parameter int unsigned DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tahmin_gecerli_i,
  input  logic [31:0] tahmin_ps_i,
  input  logic        tahmin_atladi_i,
  input  logic [31:0] tahmin_hedef_i,
  output logic        tahmin_hazir_o,
  input  logic        cozum_gecerli_i,
  input  logic        cozum_atladi_i,
  input  logic [31:0] cozum_hedef_i,
  output logic        yurut_ps_gecerli_o,
  output logic [31:0] yurut_ps_o,
  output logic        yurut_atladi_o,
  output logic        yanlis_tahmin_o,
  output logic        temizle_o,
  output logic [31:0] yonlendir_ps_o,
  output logic        hata_o,
  output logic [31:0] sayac_cozulen_o,
  output logic [31:0] sayac_yanlis_o
);

  durum_e      durum;
  tahmin_t     bas;
  tahmin_t     yazilan;
  logic        bos;
  logic        dolu;
  logic        itme_c;
  logic        cozum_c;
  logic        yanlis_c;
  logic [31:0] dogru_ps_c;

  assign yazilan = '{ps: tahmin_ps_i, atladi: tahmin_atladi_i, hedef: tahmin_hedef_i};

  assign tahmin_hazir_o = !dolu && (durum == CALIS);
  assign itme_c         = tahmin_gecerli_i && tahmin_hazir_o;
  assign cozum_c        = (durum == CALIS) && cozum_gecerli_i && !bos;

  // Direction mismatch, or both taken but to different targets
  assign yanlis_c   = (bas.atladi != cozum_atladi_i) ||
                      (bas.atladi && cozum_atladi_i && (bas.hedef != cozum_hedef_i));
  assign dogru_ps_c = cozum_atladi_i ? cozum_hedef_i : sonraki_ps(bas.ps);

  tahmin_kuyrugu #(
    .DERINLIK (DERINLIK)
  ) u_kuyruk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .itme    (itme_c),
    .cekme   (cozum_c && !yanlis_c),
    .temizle (cozum_c && yanlis_c),
    .yazilan (yazilan),
    .bas     (bas),
    .bos     (bos),
    .dolu    (dolu)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum              <= CALIS;
      yurut_ps_gecerli_o <= 1'b0;
      yurut_ps_o         <= '0;
      yurut_atladi_o     <= 1'b0;
      yanlis_tahmin_o    <= 1'b0;
      temizle_o          <= 1'b0;
      yonlendir_ps_o     <= '0;
      hata_o             <= 1'b0;
    end else begin
      yurut_ps_gecerli_o <= 1'b0;
      yanlis_tahmin_o    <= 1'b0;
      temizle_o          <= 1'b0;
      case (durum)
        CALIS: begin
          if (cozum_gecerli_i && bos) begin
            hata_o <= 1'b1;
          end
          if (cozum_c) begin
            yurut_ps_gecerli_o <= 1'b1;
            yurut_ps_o         <= bas.ps;
            yurut_atladi_o     <= cozum_atladi_i;
            yanlis_tahmin_o    <= yanlis_c;
            if (yanlis_c) begin
              temizle_o      <= 1'b1;
              yonlendir_ps_o <= dogru_ps_c;
              durum          <= TEMIZLE;
            end
          end
        end
        // Single flush cycle; resolutions arriving now belong to squashed work
        TEMIZLE: durum <= CALIS;
        default: durum <= CALIS;
      endcase
    end
  end

`ifdef DALLANMA_SAYAC_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_cozulen_o <= '0;
      sayac_yanlis_o  <= '0;
    end else begin
      if (cozum_c && (sayac_cozulen_o != 32'hFFFF_FFFF)) begin
        sayac_cozulen_o <= sayac_cozulen_o + 32'd1;
      end
      if (cozum_c && yanlis_c && (sayac_yanlis_o != 32'hFFFF_FFFF)) begin
        sayac_yanlis_o <= sayac_yanlis_o + 32'd1;
      end
    end
  end
`else
  assign sayac_cozulen_o = '0;
  assign sayac_yanlis_o  = '0;
`endif

endmodule
